// File: rtl/mux_rr_if.sv
// Handshake and data bundle between several producers and one consumer of mux_rr.
//
// Valid/ready: a word moves across a channel on a rising clk edge where that
// channel's valid and ready are both 1. The sender holds data stable while valid
// is 1 and ready is 0. Ready may depend combinationally on valid.
interface mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    // Producer/consumer side: drives the inputs and the consumer's ready.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    // Mux side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_rr.sv
// N-channel registered multiplexer with a fixed-select mode and a round-robin
// mode. One output register gives 1-cycle latency at one word per cycle.
module mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic     clk,
    input logic     rst_n,
    mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [SEL_W-1:0]    ptr;
    logic                can_load;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant_idx;
    logic                xfer;
    logic [WIDTH-1:0]    load_word;
    logic [CHANNELS-1:0] in_ready_d;
    logic                lo_found;
    logic                hi_found;
    logic [SEL_W-1:0]    lo_idx;
    logic [SEL_W-1:0]    hi_idx;

    // The output register can take a word when empty or while being drained.
    assign can_load = !bus.out_valid || bus.out_ready;
    assign xfer     = can_load && grant_valid;

    // Grant decision: fixed select, or the first valid channel at or after ptr,
    // falling back to the lowest valid channel when the scan wraps.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        lo_found    = 1'b0;
        hi_found    = 1'b0;
        lo_idx      = '0;
        hi_idx      = '0;
        if (!bus.mode) begin
            grant_idx = bus.sel;
            // sel beyond the last channel never matches, so it grants nothing
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.in_valid[i] && !lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
                if (bus.in_valid[i] && !hi_found && i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
            end
            grant_valid = lo_found;
            grant_idx   = hi_found ? hi_idx : lo_idx;
        end
    end

    // One-hot ready toward the granted producer, and the word it offers.
    always_comb begin
        in_ready_d = '0;
        load_word  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready_d[i] = can_load && grant_valid && (grant_idx == SEL_W'(i));
            if (grant_idx == SEL_W'(i)) begin
                load_word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = in_ready_d;

    // Output register: load on a transfer, clear valid when drained with no new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= load_word;
            bus.out_chan  <= grant_idx;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only on round-robin transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && bus.mode) begin
            ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end
endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr: a 4-channel and a 3-channel instance.
module tb_mux_rr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_rr_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
    mux_rr_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    mux_rr #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    mux_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00 || bus4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_init got v=%b d=%h c=%0d exp v=0 d=00 c=0",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
        rst_n = 1'b1;
        // load 0xAB on channel 0, hold it with out_ready low
        bus4.mode      = 1'b0;
        bus4.sel       = 2'd0;
        bus4.in_data   = 32'h000000AB;
        bus4.in_valid  = 4'b0001;
        bus4.out_ready = 1'b0;
        tick();
        bus4.in_valid = 4'b0000;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'hAB) begin
            errors++;
            $display("FAIL reset_load got v=%b d=%h exp v=1 d=ab", bus4.out_valid, bus4.out_data);
        end
        // reset asserted mid-cycle must clear outputs before the next edge
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00 || bus4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%h c=%0d exp v=0 d=00 c=0",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
        // an offered word must not transfer while reset is held
        bus4.in_valid  = 4'b0001;
        bus4.out_ready = 1'b1;
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got v=%b d=%h exp v=0 d=00", bus4.out_valid, bus4.out_data);
        end
        bus4.in_valid = 4'b0000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_sweep();
        logic [3:0] exp_rdy;
        bus4.mode      = 1'b0;
        bus4.in_data   = 32'h13121110;
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus4.sel = 2'(s);
            exp_rdy  = 4'b0001 << s;
            #1;
            checks++;
            if (bus4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL fixed_ready sel=%0d got %b exp %b", s, bus4.in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'(8'h10 + s) || bus4.out_chan !== 2'(s)) begin
                errors++;
                $display("FAIL fixed_out sel=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d",
                         s, bus4.out_valid, bus4.out_data, bus4.out_chan, 8'(8'h10 + s), s);
            end
        end
    endtask

    task automatic test_rr_all();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        bus4.mode      = 1'b1;
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (bus4.in_ready !== (4'b0001 << exp_seq[k])) begin
                errors++;
                $display("FAIL rr_all_ready step=%0d got %b exp ch %0d", k, bus4.in_ready, exp_seq[k]);
            end
            tick();
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_chan !== 2'(exp_seq[k]) ||
                bus4.out_data !== 8'(8'h10 + exp_seq[k])) begin
                errors++;
                $display("FAIL rr_all_out step=%0d got v=%b c=%0d d=%h exp v=1 c=%0d",
                         k, bus4.out_valid, bus4.out_chan, bus4.out_data, exp_seq[k]);
            end
        end
    endtask

    task automatic test_rr_sparse();
        // pointer is 2 after the previous grant to channel 1
        int exp_seq[5] = '{3, 1, 3, 1, 3};
        bus4.in_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus4.out_chan !== 2'(exp_seq[k]) || bus4.out_data !== 8'(8'h10 + exp_seq[k])) begin
                errors++;
                $display("FAIL rr_sparse step=%0d got c=%0d d=%h exp c=%0d",
                         k, bus4.out_chan, bus4.out_data, exp_seq[k]);
            end
        end
        // after a grant to 3 the pointer wraps to 0
        bus4.in_valid = 4'b1011;
        tick();
        checks++;
        if (bus4.out_chan !== 2'd0 || bus4.out_data !== 8'h10) begin
            errors++;
            $display("FAIL rr_wrap got c=%0d d=%h exp c=0 d=10", bus4.out_chan, bus4.out_data);
        end
    endtask

    task automatic test_backpressure();
        // channel 0 word 0x10 is held
        bus4.mode      = 1'b0;
        bus4.sel       = 2'd2;
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready cyc=%0d got %b exp 0000", k, bus4.in_ready);
            end
            tick();
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h10 || bus4.out_chan !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h c=%0d exp v=1 d=10 c=0",
                         k, bus4.out_valid, bus4.out_data, bus4.out_chan);
            end
        end
        bus4.out_ready = 1'b1;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL drain_ready got %b exp 0100", bus4.in_ready);
        end
        tick();
        bus4.in_valid = 4'b0000;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h12 || bus4.out_chan !== 2'd2) begin
            errors++;
            $display("FAIL drain_load got v=%b d=%h c=%0d exp v=1 d=12 c=2",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
        tick();
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h12 || bus4.out_chan !== 2'd2) begin
            errors++;
            $display("FAIL drain_empty got v=%b d=%h c=%0d exp v=0 d=12 c=2",
                     bus4.out_valid, bus4.out_data, bus4.out_chan);
        end
    endtask

    task automatic test_three_channels();
        int exp_seq[4] = '{0, 1, 2, 0};
        bus3.mode      = 1'b1;
        bus3.in_data   = 24'h323130;
        bus3.in_valid  = 3'b111;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus3.out_chan !== 2'(exp_seq[k]) || bus3.out_data !== 8'(8'h30 + exp_seq[k])) begin
                errors++;
                $display("FAIL ch3_rr step=%0d got c=%0d d=%h exp c=%0d",
                         k, bus3.out_chan, bus3.out_data, exp_seq[k]);
            end
        end
        // out-of-range select grants nothing; held word drains
        bus3.mode = 1'b0;
        bus3.sel  = 2'd3;
        #1;
        checks++;
        if (bus3.in_ready !== 3'b000) begin
            errors++;
            $display("FAIL ch3_sel3_ready got %b exp 000", bus3.in_ready);
        end
        tick();
        checks++;
        if (bus3.out_valid !== 1'b0 || bus3.out_data !== 8'h30) begin
            errors++;
            $display("FAIL ch3_sel3_out got v=%b d=%h exp v=0 d=30", bus3.out_valid, bus3.out_data);
        end
        // back to round-robin: resumes from stored pointer (1)
        bus3.mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus3.out_valid !== 1'b1 || bus3.out_chan !== 2'(k + 1)) begin
                errors++;
                $display("FAIL ch3_resume step=%0d got v=%b c=%0d exp v=1 c=%0d",
                         k, bus3.out_valid, bus3.out_chan, k + 1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.mode = 1'b0; bus4.sel = '0; bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
        bus3.mode = 1'b0; bus3.sel = '0; bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
        test_reset();
        test_fixed_sweep();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_three_channels();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr.md
Name: mux_rr

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output. Two modes: fixed select, where the sel port picks the channel, and round-robin arbitration across the valid channels. One output register stage gives a 1-cycle latency and full throughput. It is the generalised successor of the 2:1 combinational mux in the gates library and is used wherever several producers share one consumer.

Parameters:
WIDTH, 8, data width per channel in bits
CHANNELS, 4, number of input channels (>=2, not required to be a power of 2)
SEL_W, $clog2(CHANNELS), width of sel and out_chan; derived, never overridden

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel valid
in_ready  output  CHANNELS  per-channel ready (one-hot or zero)
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts the word
out_chan  output  SEL_W  source channel of out_data

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0.
- A held word is discarded on reset, and no transfer happens while rst_n is low.
- Load condition: can_load = !out_valid | out_ready.
- Grant, evaluated combinationally every cycle:
  - mode=0: grant_valid = (sel < CHANNELS) & in_valid[sel]; grant_idx = sel.
  - mode=1: grant_idx = first i with in_valid[i] set, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. grant_valid = |in_valid.
- in_ready[i] = can_load & grant_valid & (i == grant_idx). At most one bit is set. in_ready depends combinationally on in_valid, mode, sel and out_ready.
- Transfer: in_valid[i] & in_ready[i] at a rising edge. On that edge:
  - out_data <= channel i word
  - out_chan <= i
  - out_valid <= 1
- Output handshake: out_valid & out_ready at an edge with no new transfer -> out_valid <= 0. out_data and out_chan keep their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, out_valid stays 1. This gives back-to-back throughput of 1 word per cycle.
- Stall: while out_valid=1 and out_ready=0, out_data and out_chan are stable and all in_ready are 0.
- Round-robin pointer:
  - Updated only on a transfer in mode=1: ptr <= (grant_idx == CHANNELS-1) ? 0 : grant_idx+1.
  - Unchanged in mode=0 and on idle cycles.
- Fixed mode with sel >= CHANNELS (only possible when CHANNELS is not a power of 2): no grant, no transfer.
- Mode or sel change: applies from the next edge's decision. It never alters a word already held.
- The input side has no flow-through, so latency is exactly 1 cycle from the accepting edge to out_valid.

Test Plan:
1. Async reset: WIDTH=8, CHANNELS=4, output loaded with 0xAB; assert rst_n mid-cycle -> out_valid, out_data and out_chan read 0 before the next clk edge; no transfer while low.
2. Fixed-mode sweep: all valid, in_data ch i = 0x10+i, out_ready=1, sel=0..3 -> out_data 0x10..0x13 and out_chan 0..3, each one cycle after acceptance; in_ready is one-hot at sel.
3. Round-robin, all valid, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1 continuously.
4. Round-robin sparse: in_valid=4'b1010 -> grants alternate 1,3,1,3; then raising in_valid[0] after a grant to 3 -> next grant is 0 (pointer wrap).
5. Backpressure: out_ready=0 for 3 cycles with words pending -> out_data and out_chan stable, in_ready=0; raising out_ready -> the held word drains and the next word loads in the same cycle; no loss or duplication.
6. CHANNELS=3: round-robin grants wrap 2->0; fixed mode with sel=3 -> in_ready=0 and no transfer; switching to mode=1 mid-stream -> arbitration resumes from the stored ptr.
